// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. Synchronises the asynchronous RX line,
//            verifies the start bit at mid-bit, samples 8 data bits LSB-first
//            at mid-bit and checks the stop bit. Good bytes are presented with
//            a one-cycle valid strobe; a low stop bit gives a one-cycle
//            framing_err strobe.
// Ports    : clk          - system clock, rising edge
//            rst_n        - asynchronous active-low reset
//            rx_line      - serial line, idle high, asynchronous to clk
//            data[7:0]    - last good byte, holds between frames
//            valid        - one-cycle strobe, data is new this cycle
//            framing_err  - one-cycle strobe, stop bit sampled low
//            busy         - high in every state except IDLE
// Options  : UART_RX_MAJORITY_EN - when defined, each sample point uses the
//            majority of the synchronised line over the sample cycle and the
//            two cycles before it (same sample cycles, no added latency).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416  // legal range 8..16383
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_line,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int          HALF      = CLKS_PER_BIT / 2;
  localparam logic [13:0] C_HALF_M1 = 14'(HALF - 1);
  localparam logic [13:0] C_BIT_M1  = 14'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  logic        sync1_q;
  logic        rxs_q;
  state_t      state_q,       state_d;
  logic [13:0] prscl_q,       prscl_d;
  logic [2:0]  index_q,       index_d;
  logic [7:0]  shreg_q,       shreg_d;
  logic [7:0]  data_q,        data_d;
  logic        valid_q,       valid_d;
  logic        framing_err_q, framing_err_d;
  logic        busy_q,        busy_d;
  logic        sample_w;

`ifdef UART_RX_MAJORITY_EN
  // Two previous synchronised values; together with rxs_q they form the
  // 3-sample window voted on at each sample point.
  logic [1:0] hist_q;
  assign sample_w = (rxs_q & hist_q[0]) | (rxs_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample_w = rxs_q;
`endif

  always_comb begin
    state_d       = state_q;
    prscl_d       = prscl_q;
    index_d       = index_q;
    shreg_d       = shreg_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    framing_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        prscl_d = '0;
        index_d = '0;
        if (!rxs_q) state_d = ST_START;
      end
      ST_START: begin
        if (prscl_q == C_HALF_M1) begin
          prscl_d = '0;
          // A high sample at mid-start means the low was a glitch.
          state_d = sample_w ? ST_IDLE : ST_DATA;
        end else begin
          prscl_d = prscl_q + 14'd1;
        end
      end
      ST_DATA: begin
        if (prscl_q == C_BIT_M1) begin
          prscl_d          = '0;
          shreg_d[index_q] = sample_w;
          index_d          = index_q + 3'd1;
          if (index_q == 3'd7) state_d = ST_STOP;
        end else begin
          prscl_d = prscl_q + 14'd1;
        end
      end
      ST_STOP: begin
        if (prscl_q == C_BIT_M1) begin
          prscl_d = '0;
          if (sample_w) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;     // IDLE from mid-stop allows back-to-back frames
          end else begin
            framing_err_d = 1'b1;
            state_d       = ST_WAIT_HIGH;
          end
        end else begin
          prscl_d = prscl_q + 14'd1;
        end
      end
      ST_WAIT_HIGH: begin
        // Hold off while the line stays low (break) so it is not re-read
        // as a new start bit.
        prscl_d = '0;
        if (rxs_q) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        prscl_d = '0;
        index_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      rxs_q         <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      hist_q        <= 2'b11;
`endif
      state_q       <= ST_IDLE;
      prscl_q       <= '0;
      index_q       <= '0;
      shreg_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      framing_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sync1_q       <= rx_line;
      rxs_q         <= sync1_q;
`ifdef UART_RX_MAJORITY_EN
      hist_q        <= {hist_q[0], rxs_q};
`endif
      state_q       <= state_d;
      prscl_q       <= prscl_d;
      index_q       <= index_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      framing_err_q <= framing_err_d;
      busy_q        <= busy_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign framing_err = framing_err_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx at CLKS_PER_BIT=16. A frame-level
//            reference model, working from absolute sample times relative to
//            the detected start edge, predicts data/valid/framing_err/busy
//            every cycle; directed frames add literal timing/value checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx_line = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_line     (rx_line),
    .data        (data),
    .valid       (valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- reference model ----------------
  // m_hist[0] is the line value seen at this edge; the receiver acts on the
  // value seen two edges earlier (m_hist[2]) because of the synchroniser.
  int         m_mode  = 0;        // 0 idle, 1 in frame, 2 waiting for high
  int         m_edge  = 0;
  int         m_t0    = 0;
  int         m_off;
  int         m_ones;
  logic [4:0] m_hist  = 5'b11111;
  logic [7:0] m_bits  = 8'h00;
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_samp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_edge = 0; m_t0 = 0; m_hist = 5'b11111;
      m_bits = 8'h00; m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0;
    end else begin
      m_edge  = m_edge + 1;
      m_hist  = {m_hist[3:0], rx_line};
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ones  = int'(m_hist[2]) + int'(m_hist[3]) + int'(m_hist[4]);
`ifdef UART_RX_MAJORITY_EN
      m_samp = (m_ones >= 2);
`else
      m_samp = m_hist[2];
`endif
      case (m_mode)
        0: if (!m_hist[2]) begin m_mode = 1; m_t0 = m_edge; end
        1: begin
          m_off = m_edge - m_t0 - HALF;   // 0 = mid-start
          if (m_off == 0) begin
            if (m_samp) m_mode = 0;
          end else if (m_off > 0 && m_off % CPB == 0 && m_off / CPB <= 8) begin
            m_bits[3'(m_off / CPB - 1)] = m_samp;
          end else if (m_off == 9 * CPB) begin
            if (m_samp) begin m_data = m_bits; m_valid = 1'b1; m_mode = 0; end
            else        begin m_ferr = 1'b1; m_mode = 2; end
          end
        end
        default: if (m_hist[2]) m_mode = 0;
      endcase
    end
  end

  // ---------------- checking ----------------
  int         vectors     = 0;
  int         miscompares = 0;
  int         nprint      = 0;
  int         busy_cnt    = 0;
  int         ferr_cnt    = 0;
  int         vcyc[$];
  logic [7:0] vdat[$];

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_trk();
    busy_cnt = 0; ferr_cnt = 0; vcyc.delete(); vdat.delete();
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    rx_line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first ncyc cycles of a 160-cycle frame; glitch_at inverts one cycle.
  task automatic send(input logic [7:0] b, input logic stop_v, input int glitch_at, input int ncyc);
    logic v;
    for (int i = 0; i < ncyc; i++) begin
      if (i < CPB)          v = 1'b0;
      else if (i < 9 * CPB) v = b[(i - CPB) / CPB];
      else                  v = stop_v;
      if (i == glitch_at) v = ~v;
      rx_line = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " data"},  int'(data), 0);
    check({tag, " valid"}, int'(valid), 0);
    check({tag, " ferr"},  int'(framing_err), 0);
    check({tag, " busy"},  int'(busy), 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    rx_line = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int         s;
  int         gap;
  logic [7:0] rb;
  logic       rstop;

  initial begin
    fork
      forever begin
        @(negedge clk);
        vectors = vectors + 1;
        if (data !== m_data || valid !== m_valid || framing_err !== m_ferr ||
            busy !== (m_mode != 0)) begin
          miscompares = miscompares + 1;
          if (nprint < 20)
            $display("FAIL cycle %0d outputs dut/model: data %h/%h valid %b/%b ferr %b/%b busy %b/%b",
                     cyc, data, m_data, valid, m_valid, framing_err, m_ferr, busy, m_mode != 0);
          nprint = nprint + 1;
        end
        if (valid === 1'b1) begin vcyc.push_back(cyc); vdat.push_back(data); end
        if (framing_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
      end
    join_none

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    idle(5);

    // Ideal 0xA5: VALID at start+155 (t0 = start+3, +HALF+9*CPB)
    clear_trk(); s = cyc;
    send(8'hA5, 1'b1, -1, 160); idle(20);
    check("a5 valid count", vcyc.size(), 1);
    if (vcyc.size() >= 1) begin
      check("a5 valid cycle", vcyc[0] - s, 155);
      check("a5 data", int'(vdat[0]), 8'hA5);
    end
    check("a5 busy cycles", busy_cnt, 152);
    check("a5 ferr count", ferr_cnt, 0);

    // Back-to-back 0x00 then 0xFF
    clear_trk(); s = cyc;
    send(8'h00, 1'b1, -1, 160); send(8'hFF, 1'b1, -1, 160); idle(20);
    check("b2b valid count", vcyc.size(), 2);
    if (vcyc.size() >= 2) begin
      check("b2b first cycle", vcyc[0] - s, 155);
      check("b2b spacing", vcyc[1] - vcyc[0], 160);
      check("b2b data0", int'(vdat[0]), 8'h00);
      check("b2b data1", int'(vdat[1]), 8'hFF);
    end

    // 3-cycle low glitch is rejected at mid-start
    clear_trk();
    hold(1'b0, 3); idle(30);
    check("glitch busy cycles", busy_cnt, HALF);
    check("glitch valid count", vcyc.size(), 0);
    check("glitch ferr count", ferr_cnt, 0);

    // 0x3C with low stop bit, line held low 50 more cycles
    clear_trk();
    send(8'h3C, 1'b0, -1, 160); hold(1'b0, 50); idle(20);
    check("ferr count", ferr_cnt, 1);
    check("ferr valid count", vcyc.size(), 0);
    check("ferr data held", int'(data), 8'hFF);
    check("ferr busy cycles", busy_cnt, 210);

    // Reset in the middle of data bit 4, then a clean 0x81
    clear_trk();
    send(8'h5A, 1'b1, -1, 88);
    do_reset("midrst");
    idle(5);
    send(8'h81, 1'b1, -1, 160); idle(20);
    check("midrst valid count", vcyc.size(), 1);
    check("midrst data", int'(data), 8'h81);

    // 0x55 with a 1-cycle inversion on data bit 2's sample cycle
    clear_trk();
    send(8'h55, 1'b1, 56, 160); idle(20);
`ifdef UART_RX_MAJORITY_EN
    check("glitch55 data", int'(data), 8'h55);
`else
    check("glitch55 data", int'(data), 8'h51);
`endif

    // Randomised traffic checked by the model every cycle
    for (int n = 0; n < 200; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        0: begin
          hold(1'b0, $urandom_range(1, 12));
          idle($urandom_range(1, 20));
        end
        1: begin
          send(rb, 1'b1, -1, $urandom_range(20, 150));
          do_reset("rndrst");
          idle($urandom_range(0, 10));
        end
        default: begin
          send(rb, rstop, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 159) : -1, 160);
          if (!rstop) hold(1'b0, $urandom_range(0, 20));
          gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 25);
          if (gap > 0) idle(gap);
        end
      endcase
    end
    idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver paired with the existing 8N1 transmitter; it converts the asynchronous serial RX line into parallel bytes for the beamformer control path. The block synchronises the line, detects and verifies the start bit, samples 8 data bits LSB-first at mid-bit and checks the stop bit. Each good byte is presented with a one-cycle VALID strobe, and a bad stop bit raises a framing-error strobe. The default baud is 9600 at the 100 MHz system clock.

## Interface
- CLKS_PER_BIT, 10416: system clocks per bit; legal range 8..16383. HALF = CLKS_PER_BIT/2 (integer division).
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low. One clock, CLK; reset is asynchronous and active-low.
- RX_LINE  input  1  serial line, idle high, asynchronous to CLK.
- DATA  output  8  last good received byte; holds between frames.
- VALID  output  1  one-cycle strobe; DATA is new this cycle.
- FRAMING_ERR  output  1  one-cycle strobe; stop bit was sampled low.
- BUSY  output  1  high in every state except IDLE.

## Operation
- RX_LINE passes through a 2-flop synchroniser. Both flops reset to 1. The output of this synchroniser is RXS.
- Bit counter: 14-bit PRSCL. Bit index: 3-bit INDEX. Shift register: 8-bit SHREG.
- The state machine has five states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: PRSCL=0, INDEX=0. When RXS==0 -> START.
- START: PRSCL increments each cycle. When PRSCL==HALF-1, the start bit is sampled.
  - Sample 0 -> DATA, PRSCL=0.
  - Sample 1 -> IDLE (glitch rejected; no strobe).
- DATA: PRSCL counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1:
  - Sample RXS into SHREG[INDEX] (LSB first).
  - PRSCL=0 and INDEX increments.
  - After INDEX==7 is sampled -> STOP.
- STOP: at PRSCL==CLKS_PER_BIT-1, the stop bit is sampled.
  - Sample 1 -> DATA<=SHREG, VALID=1 for one cycle, then IDLE.
  - Sample 0 -> FRAMING_ERR=1 for one cycle, DATA unchanged, then WAIT_HIGH.
- WAIT_HIGH: stays here while RXS==0 (line held low / break). RXS==1 -> IDLE.
- VALID and FRAMING_ERR are never high in the same cycle.
- No flow control. The consumer must take DATA before the next VALID, about 10 bit times later.
- Reset at any time:
  - State=IDLE, all counters and SHREG cleared.
  - Any partial frame is discarded with no strobe.
  - After release, a line that is still low is treated as a new start bit and verified at mid-bit as usual.

## Timing
- Reset values: DATA=8'h00, VALID=0, FRAMING_ERR=0, BUSY=0.
- Define t0 as the CLK edge where the machine enters START. This is 3 edges after RX_LINE falls: 2 synchroniser edges plus 1 state edge.
- Start-bit sample: t0+HALF-1.
- Data bit k (k=0..7) sample: t0+HALF+(k+1)*CLKS_PER_BIT-1.
- Stop-bit sample: t0+HALF+9*CLKS_PER_BIT-1.
- VALID or FRAMING_ERR is registered high on the next edge and lasts exactly 1 cycle. BUSY falls on that same edge for a good frame.
- Back-to-back frames:
  - IDLE is re-entered at mid-stop.
  - A start edge arriving half a bit later is accepted.
  - No minimum idle time beyond the stop bit's second half is required.
- Total sampling drift tolerated is ±HALF clocks over 10 bits, i.e. about ±5% baud mismatch.

## Configuration
- Macro: UART_RX_MAJORITY_EN.
- When defined:
  - A 3-bit history of RXS feeds every sample point (start, data and stop bits).
  - Each sampled value is the majority of RXS at the sample cycle and the two cycles before it.
  - Sample-point cycles are unchanged, and added latency is 0.
- When undefined: each sample is the single RXS value at the sample cycle.

## Test plan
- CLKS_PER_BIT=16, send 0xA5 as an ideal 8N1 frame:
  - VALID pulses once at t0+8+9*16 with DATA=0xA5.
  - BUSY is high from t0 to that edge.
  - FRAMING_ERR stays 0.
- Back-to-back 0x00 then 0xFF with no idle gap -> two VALID pulses 160 cycles apart, DATA=0x00 then 0xFF.
- RX_LINE low for 3 cycles, then high -> BUSY pulses for about HALF cycles, returns to IDLE; no VALID, no FRAMING_ERR.
- Frame 0x3C with stop bit forced 0, line then held low 50 cycles -> FRAMING_ERR pulses once and DATA stays at its prior value. BUSY stays high until 1 cycle after RXS returns high.
- RST_N asserted during data bit 4 of a frame -> all outputs go to reset values immediately; no strobe. A following clean 0x81 is received correctly.
- With UART_RX_MAJORITY_EN defined, send 0x55 with a 1-cycle inverted glitch exactly on data bit 2's sample cycle -> DATA=0x55. With the macro undefined, the same stimulus gives DATA=0x51.
